key_cmd_scheduler: RTL and testbench

KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

---
 rtl/key_cmd_scheduler.sv | 173 +++++++++++++++++
 tb/tb_key_cmd_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_scheduler.sv
// PS/2 keyboard decoder that turns ship keys into per-frame movement commands and rate-limited shots.
// Define FIRE_AUTOREPEAT_EN to keep firing once per cooldown period while fire is held.
module key_cmd_scheduler #(
    parameter int FIRE_COOLDOWN = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       frame_tick,
    input  logic       cmd_ack,
    output logic       cmd_valid,
    output logic [3:0] ship_control,
    output logic       fire_req,
    output logic [5:0] key_state,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_t;

    localparam logic [3:0] COOL_LOAD = 4'(FIRE_COOLDOWN);
    localparam logic [2:0] CODE_STOP = 3'd5;

    dec_state_t state, state_n;
    logic       make, brk, ext_sel;
    logic [5:0] key_hot, key_state_n;
    logic [2:0] last_key, last_key_n, cmd_val;
    logic [3:0] cooldown, cooldown_n, cd_dec;
    logic       fire_arm, fire_arm_n, arm_eff, shoot;

    // Key bitmap order: {fire, stop, up, down, right, left}
    function automatic logic [5:0] decode_key(input logic [7:0] code, input logic ext);
        logic [5:0] hot;
        hot = 6'b0;
        if (ext) begin
            case (code)
                8'h6B: hot = 6'b000001;
                8'h74: hot = 6'b000010;
                8'h72: hot = 6'b000100;
                8'h75: hot = 6'b001000;
                default: hot = 6'b0;
            endcase
        end else begin
            case (code)
                8'h1C: hot = 6'b000001;
                8'h23: hot = 6'b000010;
                8'h1B: hot = 6'b000100;
                8'h1D: hot = 6'b001000;
                8'h29: hot = 6'b010000;
                8'h5A: hot = 6'b100000;
                default: hot = 6'b0;
            endcase
        end
        return hot;
    endfunction

    // One-hot movement bit to command code (left=1 .. stop=5), 0 = none
    function automatic logic [2:0] encode_mv(input logic [4:0] mv);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 5; i++)
            if (mv[i]) c = 3'(i + 1);
        return c;
    endfunction

    function automatic logic [2:0] prio_mv(input logic [4:0] held);
        logic [2:0] c;
        if (held[3])      c = 3'd4;
        else if (held[2]) c = 3'd3;
        else if (held[0]) c = 3'd1;
        else if (held[1]) c = 3'd2;
        else if (held[4]) c = 3'd5;
        else              c = 3'd0;
        return c;
    endfunction

    always_comb begin
        state_n = state;
        make    = 1'b0;
        brk     = 1'b0;
        ext_sel = 1'b0;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_code == 8'hF0)      state_n = BRK;
                    else if (scan_code == 8'hE0) state_n = EXT;
                    else                         make = 1'b1;
                end
                BRK: begin
                    brk     = 1'b1;
                    state_n = IDLE;
                end
                EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_n = EXT_BRK;
                    end else begin
                        make    = 1'b1;
                        ext_sel = 1'b1;
                        state_n = IDLE;
                    end
                end
                EXT_BRK: begin
                    brk     = 1'b1;
                    ext_sel = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        key_hot     = decode_key(scan_code, ext_sel);
        key_state_n = key_state;
        if (make) key_state_n = key_state | key_hot;
        if (brk)  key_state_n = key_state & ~key_hot;

        // Typematic repeats of an already-held key must not steal direction
        last_key_n = last_key;
        if (make && |(key_hot[4:0] & ~key_state[4:0]))
            last_key_n = encode_mv(key_hot[4:0]);
        else if (brk && |key_hot[4:0] && encode_mv(key_hot[4:0]) == last_key)
            last_key_n = prio_mv(key_state[4:0] & ~key_hot[4:0]);

        cmd_val = (last_key == 3'd0) ? CODE_STOP : last_key;

        // Shot is judged against the post-decrement count so shots land FIRE_COOLDOWN ticks apart
        cd_dec = (cooldown == 4'd0) ? 4'd0 : cooldown - 4'd1;
`ifdef FIRE_AUTOREPEAT_EN
        arm_eff = fire_arm | key_state[5];
`else
        arm_eff = fire_arm;
`endif
        shoot = frame_tick & arm_eff & (cd_dec == 4'd0);

        cooldown_n = cooldown;
        if (frame_tick) cooldown_n = shoot ? COOL_LOAD : cd_dec;

        fire_arm_n = fire_arm;
        if (shoot) fire_arm_n = 1'b0;
        if (make && key_hot[5] && !key_state[5]) fire_arm_n = 1'b1;
        if (brk && key_hot[5]) fire_arm_n = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            key_state    <= 6'b0;
            last_key     <= 3'd0;
            cmd_valid    <= 1'b0;
            ship_control <= 4'd5;
            fire_req     <= 1'b0;
            overrun      <= 1'b0;
            cooldown     <= 4'd0;
            fire_arm     <= 1'b0;
        end else begin
            state     <= state_n;
            key_state <= key_state_n;
            last_key  <= last_key_n;
            cooldown  <= cooldown_n;
            fire_arm  <= fire_arm_n;
            fire_req  <= shoot;
            overrun   <= frame_tick & cmd_valid & ~cmd_ack;
            if (frame_tick) begin
                ship_control <= {1'b0, cmd_val};
                cmd_valid    <= 1'b1;
            end else if (cmd_ack && cmd_valid) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler: key decode, direction priority, command handshake, fire cadence.
module tb_key_cmd_scheduler;

    logic       clk;
    logic       resetn;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_tick;
    logic       cmd_ack;
    logic       cmd_valid;
    logic [3:0] ship_control;
    logic       fire_req;
    logic [5:0] key_state;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    key_cmd_scheduler #(.FIRE_COOLDOWN(3)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .scan_code    (scan_code),
        .scan_valid   (scan_valid),
        .frame_tick   (frame_tick),
        .cmd_ack      (cmd_ack),
        .cmd_valid    (cmd_valid),
        .ship_control (ship_control),
        .fire_req     (fire_req),
        .key_state    (key_state),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1ns after the edge
    task automatic step(input logic [7:0] b, input logic v, input logic t, input logic a);
        scan_code  = b;
        scan_valid = v;
        frame_tick = t;
        cmd_ack    = a;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
        frame_tick = 1'b0;
        cmd_ack    = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic tick();
        step(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic ack();
        step(8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #2;
        check("rst_key_state", {2'b0, key_state}, 8'h00);
        check("rst_cmd_valid", {7'b0, cmd_valid}, 8'h00);
        check("rst_ship_ctrl", {4'b0, ship_control}, 8'h05);
        check("rst_fire_req", {7'b0, fire_req}, 8'h00);
        check("rst_overrun", {7'b0, overrun}, 8'h00);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_fire;
        resetn     = 1'b0;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        frame_tick = 1'b0;
        cmd_ack    = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Up key, tick, ack
        send(8'h1D);
        check("up_make_ks", {2'b0, key_state}, 8'h08);
        tick();
        check("up_cmd_valid", {7'b0, cmd_valid}, 8'h01);
        check("up_ship_ctrl", {4'b0, ship_control}, 8'h04);
        ack();
        check("up_acked", {7'b0, cmd_valid}, 8'h00);
        send(8'hF0); send(8'h1D);
        check("up_break_ks", {2'b0, key_state}, 8'h00);

        // Left, right, release right -> left
        send(8'h1C); send(8'h23); send(8'hF0); send(8'h23);
        check("lr_ks", {2'b0, key_state}, 8'h01);
        tick();
        check("lr_ship_left", {4'b0, ship_control}, 8'h01);
        ack();
        send(8'hF0); send(8'h1C);
        tick();
        check("lr_ship_stop", {4'b0, ship_control}, 8'h05);
        ack();

        // Extended up make/break
        send(8'hE0); send(8'h75);
        check("ext_up_make", {2'b0, key_state}, 8'h08);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_up_break", {2'b0, key_state}, 8'h00);
        tick();
        check("ext_ship_stop", {4'b0, ship_control}, 8'h05);
        ack();

        // Typematic repeat of held left must not override right
        send(8'h1C); send(8'h23); send(8'h1C);
        tick();
        check("typematic_right", {4'b0, ship_control}, 8'h02);
        ack();
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h23);

        // Priority reload: up, down, left held; release left -> up
        send(8'h1D); send(8'h1B); send(8'h1C);
        send(8'hF0); send(8'h1C);
        check("prio_ks", {2'b0, key_state}, 8'h0C);
        tick();
        check("prio_up", {4'b0, ship_control}, 8'h04);
        ack();
        send(8'hF0); send(8'h1D);
        tick();
        check("prio_down", {4'b0, ship_control}, 8'h03);
        ack();
        send(8'hF0); send(8'h1B);

        // Unmapped code is ignored
        send(8'h15);
        check("ignored_code", {2'b0, key_state}, 8'h00);

        // Overrun and simultaneous tick+ack
        tick();
        check("ovr_first_valid", {7'b0, cmd_valid}, 8'h01);
        check("ovr_first_none", {7'b0, overrun}, 8'h00);
        tick();
        check("ovr_pulse", {7'b0, overrun}, 8'h01);
        check("ovr_valid_held", {7'b0, cmd_valid}, 8'h01);
        idle();
        check("ovr_one_cycle", {7'b0, overrun}, 8'h00);
        step(8'h00, 1'b0, 1'b1, 1'b1);
        check("tick_ack_no_ovr", {7'b0, overrun}, 8'h00);
        check("tick_ack_valid", {7'b0, cmd_valid}, 8'h01);
        ack();
        check("ack_clears", {7'b0, cmd_valid}, 8'h00);
        ack();
        check("ack_idle_ignored", {7'b0, cmd_valid}, 8'h00);

        // Byte and tick in the same cycle: tick uses the pre-byte keys
        step(8'h1D, 1'b1, 1'b1, 1'b0);
        check("same_cycle_old", {4'b0, ship_control}, 8'h05);
        ack();
        tick();
        check("same_cycle_new", {4'b0, ship_control}, 8'h04);
        ack();
        send(8'hF0); send(8'h1D);

        // Reset after F0 discards the partial break
        send(8'hF0);
        do_reset();
        send(8'h1C);
        check("post_reset_make", {2'b0, key_state}, 8'h01);

        // Fire held over 10 ticks with cooldown 3
        do_reset();
        send(8'h5A);
        for (int t = 1; t <= 10; t++) begin
            tick();
`ifdef FIRE_AUTOREPEAT_EN
            exp_fire = (t == 1 || t == 4 || t == 7 || t == 10);
`else
            exp_fire = (t == 1);
`endif
            check($sformatf("fire_tick%0d", t), {7'b0, fire_req}, {7'b0, exp_fire});
            ack();
            check($sformatf("fire_gap%0d", t), {7'b0, fire_req}, 8'h00);
            if (t == 5) send(8'h5A);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
